// File: rtl/hyper_tx_prefetch.sv
// hyper_tx_prefetch: credit-based uDMA TX prefetch FIFO feeding the hyperbus macro write stream
// Ports:
//   sys_clk_i, rstn_i             clock, asynchronous active-low reset
//   start_i, abort_i              start pulse (len_i/datasize_i sampled), abort of a running transfer
//   busy_o, done_o, level_o       not-idle flag, completion pulse, FIFO occupancy
//   tx_req_o/tx_gnt_i             uDMA TX request handshake
//   tx_valid_i/tx_data_i/tx_ready_o  uDMA returned data
//   tx_datasize_o                 latched datasize for the channel
//   out_valid_o/out_ready_i/out_data_o/out_last_o  word stream to the macro
// Optional: HYPER_TX_PREFETCH_STALL_CNT_EN adds stall_cnt_o, a saturating count of starved RUN cycles.
module hyper_tx_prefetch #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int LEN_WIDTH  = 20
) (
   input  logic                    sys_clk_i,
   input  logic                    rstn_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   input  logic [1:0]              datasize_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    tx_req_o,
   input  logic                    tx_gnt_i,
   input  logic                    tx_valid_i,
   input  logic [DATA_WIDTH-1:0]   tx_data_i,
   output logic                    tx_ready_o,
   output logic [1:0]              tx_datasize_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic                    out_last_o
`ifdef HYPER_TX_PREFETCH_STALL_CNT_EN
   ,
   output logic [15:0]             stall_cnt_o
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;
   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wptr, r_rptr;
   logic [AW:0]           r_level, r_outst;
   logic [LEN_WIDTH-1:0]  r_req_left, r_out_left;
   logic [1:0]            r_datasize;
   logic                  r_done;
   logic [1:0]            w_shift;
   logic [LEN_WIDTH-1:0]  w_mask, w_beats;
   logic                  w_start, w_abort, w_gnt, w_ret, w_push, w_pop, w_last_pop;
   // ceil(len / B) as floor plus a carry from any leftover bytes
   assign w_shift    = datasize_i == 2'b00 ? 2'd0 : datasize_i == 2'b01 ? 2'd1 : 2'd2;
   assign w_mask     = w_shift == 2'd0 ? '0 : w_shift == 2'd1 ? LEN_WIDTH'(1) : LEN_WIDTH'(3);
   assign w_beats    = (len_i >> w_shift) + LEN_WIDTH'(|(len_i & w_mask));
   assign w_start    = r_state == IDLE && start_i;
   assign w_abort    = r_state == RUN && abort_i;
   assign w_gnt      = tx_req_o && tx_gnt_i;
   assign w_ret      = tx_valid_i && tx_ready_o;
   assign w_push     = w_ret && r_state == RUN;
   assign w_pop      = out_valid_o && out_ready_i;
   assign w_last_pop = w_pop && r_out_left == LEN_WIDTH'(1);
   // Credits: words in the FIFO plus words still in flight never exceed DEPTH
   assign tx_req_o      = r_state == RUN && r_req_left != '0 && (r_level + r_outst) < FULL;
   assign tx_ready_o    = r_outst != '0;
   assign busy_o        = r_state != IDLE;
   assign done_o        = r_done;
   assign level_o       = r_level;
   assign tx_datasize_o = r_datasize;
   assign out_valid_o   = r_level != '0;
   assign out_data_o    = out_valid_o ? r_mem[r_rptr] : '0;
   assign out_last_o    = out_valid_o && r_out_left == LEN_WIDTH'(1);
   always_comb begin
      w_state_nxt = r_state;
      if (w_start && w_beats != '0) w_state_nxt = RUN;
      else if (w_abort) w_state_nxt = ABORT;
      else if (w_last_pop) w_state_nxt = IDLE;
      else if (r_state == ABORT && r_outst == '0) w_state_nxt = IDLE;
   end
   always_ff @(posedge sys_clk_i or negedge rstn_i)
      if (!rstn_i) r_state <= IDLE;
      else r_state <= w_state_nxt;
   always_ff @(posedge sys_clk_i)
      if (w_push) r_mem[r_wptr] <= tx_data_i;
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_outst    <= '0;
         r_req_left <= '0;
         r_out_left <= '0;
         r_datasize <= '0;
         r_done     <= 1'b0;
      end else begin
         // Abort wins over a coincident last pop, so no done pulse on abort
         r_done  <= (w_start && w_beats == '0) || (w_last_pop && !w_abort);
         r_outst <= r_outst + (AW+1)'(w_gnt) - (AW+1)'(w_ret);
         if (w_start) begin
            r_datasize <= datasize_i;
            r_req_left <= w_beats;
            r_out_left <= w_beats;
         end else if (w_abort) begin
            r_req_left <= '0;
            r_out_left <= '0;
            r_level    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
         end else begin
            if (w_gnt) r_req_left <= r_req_left - LEN_WIDTH'(1);
            if (w_pop) r_out_left <= r_out_left - LEN_WIDTH'(1);
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
         end
      end
   end
   always_ff @(posedge sys_clk_i)
      if (rstn_i) assert (!(w_push && !w_pop && r_level == FULL));
`ifdef HYPER_TX_PREFETCH_STALL_CNT_EN
   logic [15:0] r_stall;
   always_ff @(posedge sys_clk_i or negedge rstn_i)
      if (!rstn_i) r_stall <= '0;
      else if (w_start) r_stall <= '0;
      else if (r_state == RUN && out_ready_i && !out_valid_o && r_stall != '1) r_stall <= r_stall + 16'd1;
   assign stall_cnt_o = r_stall;
`endif
endmodule

// File: tb/tb_hyper_tx_prefetch.sv
// tb_hyper_tx_prefetch: directed self-checking bench for hyper_tx_prefetch
module tb_hyper_tx_prefetch;
   localparam int DW = 32;
   localparam int DEPTH = 8;
   localparam int LW = 20;
   logic sys_clk_i = 1'b0, rstn_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
   logic tx_gnt_i = 1'b0, tx_valid_i = 1'b0, out_ready_i = 1'b0;
   logic [LW-1:0] len_i = '0;
   logic [1:0] datasize_i = '0;
   logic [DW-1:0] tx_data_i = '0;
   logic busy_o, done_o, tx_req_o, tx_ready_o, out_valid_o, out_last_o;
   logic [3:0] level_o;
   logic [1:0] tx_datasize_o;
   logic [DW-1:0] out_data_o;
`ifdef HYPER_TX_PREFETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_o;
`endif
   int checks = 0, errors = 0;
   int lat = 2, grants = 0, beats = 0, dones = 0, rets = 0, tot = 0, cyc = 0, pop_cyc = -1, done_cyc = -1, rets0 = 0;
   logic [15:0] pipe = '0;
   logic [DW-1:0] src = 32'hA000_0000, exp_d = 32'hA000_0000;

   always #5 sys_clk_i = ~sys_clk_i;

   hyper_tx_prefetch #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
      .sys_clk_i(sys_clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
      .len_i(len_i), .datasize_i(datasize_i), .busy_o(busy_o), .done_o(done_o),
      .level_o(level_o), .tx_req_o(tx_req_o), .tx_gnt_i(tx_gnt_i), .tx_valid_i(tx_valid_i),
      .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o), .tx_datasize_o(tx_datasize_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_last_o(out_last_o)
`ifdef HYPER_TX_PREFETCH_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clr();
      grants = 0; beats = 0; dones = 0; rets = 0; cyc = 0; pop_cyc = -1; done_cyc = -1;
   endtask

   task automatic tick();
      logic g;
      tx_valid_i = pipe[0];
      tx_data_i = pipe[0] ? src : '0;
      #1;
      g = tx_req_o && tx_gnt_i;
      if (g) grants++;
      if (tx_valid_i && tx_ready_o) begin
         src++;
         rets++;
      end
      if (done_o) begin
         dones++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid_o && out_ready_i) begin
         beats++;
         check("data", out_data_o, exp_d);
         exp_d++;
         check("last", 32'(out_last_o), 32'(beats == tot));
         if (beats == tot) pop_cyc = cyc;
      end
      @(posedge sys_clk_i);
      pipe = pipe >> 1;
      if (g) pipe[lat-1] = 1'b1;
      @(negedge sys_clk_i);
      cyc++;
   endtask

   task automatic start(input int len, input logic [1:0] ds, input int nb);
      clr();
      tot = nb;
      exp_d = src;
      len_i = LW'(len);
      datasize_i = ds;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic run_done(input int budget);
      for (int i = 0; i < budget && dones == 0; i++) tick();
      check("done_seen", 32'(dones > 0), 32'd1);
   endtask

   initial begin
      @(negedge sys_clk_i);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_outs", {26'd0, done_o, tx_req_o, tx_ready_o, out_valid_o, out_last_o, 1'b0}, 32'd0);
      check("rst_level", 32'(level_o), 32'd0);
      rstn_i = 1'b1;
      tick();

      tx_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 2;
      start(32, 2'b10, 8);
      run_done(60);
      check("t1_grants", grants, 8);
      check("t1_beats", beats, 8);
      check("t1_done_lat", done_cyc, pop_cyc + 1);
      check("t1_busy", 32'(busy_o), 32'd0);
      check("t1_dsize", 32'(tx_datasize_o), 32'd2);
      tick(); tick();
      check("t1_done_once", dones, 1);

      out_ready_i = 1'b0;
      start(64, 2'b10, 16);
      repeat (40) tick();
      check("t2_grants", grants, 8);
      check("t2_level", 32'(level_o), 32'd8);
      check("t2_req", 32'(tx_req_o), 32'd0);
      out_ready_i = 1'b1;
      run_done(100);
      check("t2_beats", beats, 16);
      check("t2_grants_all", grants, 16);

      start(5, 2'b01, 3);
      run_done(40);
      check("t3_beats", beats, 3);
      check("t3_grants", grants, 3);
      check("t3_last_at", pop_cyc, done_cyc - 1);

      start(0, 2'b10, 0);
      check("t3z_done", 32'(done_o), 32'd1);
      check("t3z_busy", 32'(busy_o), 32'd0);
      check("t3z_req", 32'(tx_req_o), 32'd0);
      tick();
      tick();
      check("t3z_done_once", dones, 1);
      check("t3z_grants", grants, 0);

      out_ready_i = 1'b0;
      start(64, 2'b10, 16);
      for (int i = 0; i < 20 && grants < 4; i++) tick();
      tx_gnt_i = 1'b0;
      repeat (4) tick();
      check("t4_level4", 32'(level_o), 32'd4);
      lat = 10; tx_gnt_i = 1'b1;
      for (int i = 0; i < 20 && grants < 7; i++) tick();
      tx_gnt_i = 1'b0;
      check("t4_level_pre", 32'(level_o), 32'd4);
      check("t4_ready_pre", 32'(tx_ready_o), 32'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("t4_valid_drop", 32'(out_valid_o), 32'd0);
      check("t4_level_flush", 32'(level_o), 32'd0);
      check("t4_req_drop", 32'(tx_req_o), 32'd0);
      check("t4_busy_wait", 32'(busy_o), 32'd1);
      rets0 = rets;
      for (int i = 0; i < 30 && busy_o; i++) tick();
      check("t4_discards", rets - rets0, 3);
      check("t4_idle", 32'(busy_o), 32'd0);
      check("t4_no_done", dones, 0);
      lat = 2; tx_gnt_i = 1'b1; out_ready_i = 1'b1;
      start(16, 2'b10, 4);
      run_done(40);
      check("t4_fresh_beats", beats, 4);
      check("t4_fresh_grants", grants, 4);

      start(32, 2'b10, 8);
      repeat (5) tick();
      #2 rstn_i = 1'b0;
      #1;
      check("t5_busy", 32'(busy_o), 32'd0);
      check("t5_outs", {26'd0, done_o, tx_req_o, tx_ready_o, out_valid_o, out_last_o, 1'b0}, 32'd0);
      check("t5_level", 32'(level_o), 32'd0);
      check("t5_data", out_data_o, 32'd0);
      check("t5_dsize", 32'(tx_datasize_o), 32'd0);
      pipe = '0;
      @(negedge sys_clk_i);
      rstn_i = 1'b1;
      clr();
      pipe = 16'h0001;
      tick();
      check("t5_stray_rets", rets, 0);
      check("t5_stray_level", 32'(level_o), 32'd0);
      check("t5_stray_valid", 32'(out_valid_o), 32'd0);
      start(8, 2'b10, 2);
      run_done(40);
      check("t5_beats", beats, 2);

`ifdef HYPER_TX_PREFETCH_STALL_CNT_EN
      lat = 5;
      start(4, 2'b10, 1);
      run_done(40);
      check("stall_cnt", 32'(stall_cnt_o), 32'd6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hyper_tx_prefetch.md
Name: hyper_tx_prefetch

Overview:
- Sits between the uDMA linear TX channel and the hyperbus macro transmit datapath, on the macro side of the uDMA-to-macro bridge.
- Issues read requests on the uDMA TX channel ahead of the macro's demand and buffers the returned words in a FIFO.
- Uses credits so that returned data can never overflow the FIFO.
- Presents a valid/ready word stream with a last flag to the macro write path, and supports clean abort.

Parameters:
- DATA_WIDTH, 32, width of TX channel data and output stream.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- LEN_WIDTH, 20, width of the byte-length field (uDMA transfer size).

Ports:
- sys_clk_i  in  1  single clock.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that starts a transfer.
- abort_i  in  1  level/pulse that aborts the current transfer.
- len_i  in  LEN_WIDTH  transfer length in bytes, sampled on start_i.
- datasize_i  in  2  00 byte, 01 half, 10 word, 11 treated as word; sampled on start_i.
- busy_o  out  1  high when state is not IDLE.
- done_o  out  1  one-cycle pulse when the last word is consumed.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- tx_req_o  out  1  uDMA TX request.
- tx_gnt_i  in  1  uDMA TX grant.
- tx_valid_i  in  1  uDMA returned data valid.
- tx_data_i  in  DATA_WIDTH  uDMA returned data.
- tx_ready_o  out  1  uDMA data ready.
- tx_datasize_o  out  2  latched datasize, driven to the channel.
- out_valid_o  out  1  stream valid to the macro.
- out_ready_i  in  1  stream ready from the macro.
- out_data_o  out  DATA_WIDTH  stream data.
- out_last_o  out  1  marks the final beat; qualified by out_valid_o.

Behaviour:
- Reset values: all outputs 0, FIFO empty, all counters 0, state IDLE.
- Beat count: beats = ceil(len_i / B), where B = 1, 2 or 4 per the latched datasize.
  - Computed at start and loaded into req_left and out_left.
- States and transitions:
  - IDLE: start_i moves to RUN. If beats == 0, done_o pulses the next cycle and the state stays IDLE.
  - RUN: normal operation; requests and stream output active.
  - ABORT: entered from RUN on abort_i.
  - RUN -> IDLE when out_left reaches 0.
  - ABORT -> IDLE when outstanding == 0.
- start_i while busy is ignored. abort_i in IDLE is ignored.
- Request issue:
  - tx_req_o = (state == RUN) && req_left != 0 && (level + outstanding) < DEPTH.
  - tx_req_o is combinational from registered state only.
  - On tx_req_o && tx_gnt_i: req_left decrements and outstanding increments.
- Data return:
  - tx_ready_o = (outstanding != 0).
  - On tx_valid_i && tx_ready_o: in RUN the word is pushed into the FIFO; in ABORT it is discarded. Outstanding decrements in both cases.
  - Grant and valid in the same cycle leave outstanding unchanged.
  - tx_valid_i with outstanding == 0 is a protocol violation; the data is dropped and no state changes.
- FIFO and stream output:
  - Registered output, no fall-through: a word pushed in cycle N is visible on out_valid_o at N+1 at the earliest.
  - Simultaneous push and pop are allowed at any level, including full; level is unchanged.
  - Credits guarantee that a push never occurs while the FIFO is full. An overflow attempt is an assertion failure.
  - Pop on out_valid_o && out_ready_i, which decrements out_left.
  - out_last_o = out_valid_o && out_left == 1.
  - The pop of the last beat produces a done_o pulse on the next cycle and returns the state to IDLE.
- Abort:
  - abort_i sampled high in RUN flushes the FIFO (out_valid_o low from the next cycle) and clears req_left.
  - The block then waits in ABORT until all outstanding grants have returned.
  - done_o is not pulsed on abort.
- Reset mid-operation clears everything immediately. In-flight uDMA returns after reset are dropped (outstanding == 0).
- Data words pass through unmodified; byte packing is the macro's job.

Optional Feature:
- Macro: HYPER_TX_PREFETCH_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o (16 bits, saturating).
  - Counts cycles in RUN where out_ready_i == 1 and out_valid_o == 0, i.e. the macro is starved.
  - Cleared on start_i; holds its value in IDLE.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Basic transfer: len=32, datasize=10, gnt always 1, valid 2 cycles after gnt, out_ready=1.
  - Exactly 8 req handshakes and 8 output beats, in order.
  - out_last_o on beat 8; done_o 1 cycle after the final pop; busy_o low afterwards.
- Back-pressure: len=64, DEPTH=8, out_ready=0 for 40 cycles.
  - tx_req_o stops after 8 grants and level_o==8, with no overflow.
  - Releasing out_ready resumes requests; all 16 words are delivered.
- Rounding and zero length:
  - len=5, datasize=01 gives 3 beats, last on beat 3.
  - len=0 gives no tx_req_o and a done_o pulse the cycle after start.
- Abort with 3 outstanding grants and 4 FIFO words:
  - out_valid_o drops next cycle; tx_req_o drops; the 3 late valids are accepted and discarded.
  - busy_o falls after the last return; no done_o.
  - A following start of 16 bytes delivers exactly 4 fresh words.
- Reset mid-transfer: rstn_i low during RUN.
  - All outputs 0 asynchronously.
  - After release, a stray tx_valid_i is ignored and a new transfer works.
- With HYPER_TX_PREFETCH_STALL_CNT_EN: valid latency forced to 5 cycles, len=4, out_ready=1.
  - stall_cnt_o == 6 at done (cycles from RUN entry until out_valid_o).
